mips_exec_mem_unit: RTL and testbench

Combinational instruction decoder, 32-bit ALU and word-addressed data memory for the 5-stage MIPS pipeline. The ID stage drives `opcode`/`funct` into the decoder. EX drives the ALU. MEM drives the data memory. All pipeline registers, forwarding and hazard logic stay outside this block.

---
 rtl/mips_pkg.sv | 27 ++
 rtl/mips_main_decoder.sv | 88 ++++++++
 rtl/mips_exec_mem_unit.sv | 77 +++++++
 tb/tb_mips_exec_mem_unit.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcode, funct and ALU operation codes shared by the MIPS EX/MEM block
package mips_pkg;
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;
    localparam logic [3:0] ALU_XOR = 4'b1101;
endpackage

// File: rtl/mips_main_decoder.sv
// mips_main_decoder: opcode/funct to control bits; NOR/XOR funct decode only with ALU_EXT_OPS_EN
module mips_main_decoder
    import mips_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output logic       regdst,
    output logic       alusrc,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       memread,
    output logic       memwrite,
    output logic       branch_eq,
    output logic       branch_ne,
    output logic       jump,
    output logic [3:0] aluctl
);
    logic       fn_ok;
    logic [3:0] fn_ctl;

    always_comb begin
        fn_ok = 1'b1;
        fn_ctl = ALU_AND;
        case (funct)
            FN_ADD: fn_ctl = ALU_ADD;
            FN_SUB: fn_ctl = ALU_SUB;
            FN_AND: fn_ctl = ALU_AND;
            FN_OR:  fn_ctl = ALU_OR;
            FN_SLT: fn_ctl = ALU_SLT;
`ifdef ALU_EXT_OPS_EN
            FN_NOR: fn_ctl = ALU_NOR;
            FN_XOR: fn_ctl = ALU_XOR;
`endif
            default: fn_ok = 1'b0;
        endcase
    end

    always_comb begin
        regdst = 1'b0;
        alusrc = 1'b0;
        memtoreg = 1'b0;
        regwrite = 1'b0;
        memread = 1'b0;
        memwrite = 1'b0;
        branch_eq = 1'b0;
        branch_ne = 1'b0;
        jump = 1'b0;
        aluctl = ALU_AND;
        case (opcode)
            OP_RTYPE: begin
                regdst = 1'b1;
                regwrite = fn_ok;
                aluctl = fn_ctl;
            end
            OP_LW: begin
                alusrc = 1'b1;
                memtoreg = 1'b1;
                regwrite = 1'b1;
                memread = 1'b1;
                aluctl = ALU_ADD;
            end
            OP_SW: begin
                alusrc = 1'b1;
                memwrite = 1'b1;
                aluctl = ALU_ADD;
            end
            OP_BEQ: begin
                branch_eq = 1'b1;
                aluctl = ALU_SUB;
            end
            OP_BNE: begin
                branch_ne = 1'b1;
                aluctl = ALU_SUB;
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                alusrc = 1'b1;
                regwrite = 1'b1;
                aluctl = opcode == OP_ADDI ? ALU_ADD : opcode == OP_ANDI ? ALU_AND :
                         opcode == OP_ORI ? ALU_OR : ALU_SLT;
            end
            OP_J: begin
                jump = 1'b1;
                aluctl = ALU_ADD;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mips_exec_mem_unit.sv
// mips_exec_mem_unit: MIPS decoder, 32-bit ALU and word-addressed data memory
// NOR/XOR ALU ops are enabled by defining ALU_EXT_OPS_EN.
module mips_exec_mem_unit
    import mips_pkg::*;
#(
    parameter int DM_WORDS = 128
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic        regdst,
    output logic        alusrc,
    output logic        memtoreg,
    output logic        regwrite,
    output logic        memread,
    output logic        memwrite,
    output logic        branch_eq,
    output logic        branch_ne,
    output logic        jump,
    output logic [3:0]  aluctl,
    input  logic [3:0]  alu_ctl,
    input  logic [31:0] alu_a,
    input  logic [31:0] alu_b,
    output logic [31:0] alu_out,
    output logic        alu_zero,
    input  logic [31:0] mem_addr,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata
);
    localparam int AW = $clog2(DM_WORDS);

    logic [31:0] mem [DM_WORDS];
    logic [29:0] widx;
    logic        in_range;
    logic        unused_byte_bits;

    mips_main_decoder u_dec (
        .opcode(opcode), .funct(funct), .regdst(regdst), .alusrc(alusrc),
        .memtoreg(memtoreg), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .branch_eq(branch_eq), .branch_ne(branch_ne),
        .jump(jump), .aluctl(aluctl)
    );

    always_comb begin
        case (alu_ctl)
            ALU_AND: alu_out = alu_a & alu_b;
            ALU_OR:  alu_out = alu_a | alu_b;
            ALU_ADD: alu_out = alu_a + alu_b;
            ALU_SUB: alu_out = alu_a - alu_b;
            ALU_SLT: alu_out = {31'd0, $signed(alu_a) < $signed(alu_b)};
`ifdef ALU_EXT_OPS_EN
            ALU_NOR: alu_out = ~(alu_a | alu_b);
            ALU_XOR: alu_out = alu_a ^ alu_b;
`endif
            default: alu_out = '0;
        endcase
    end

    assign alu_zero = alu_out == '0;

    assign widx = mem_addr[31:2];
    assign unused_byte_bits = ^mem_addr[1:0];
    assign in_range = {2'b00, widx} < DM_WORDS;
    assign mem_rdata = mem_rd && in_range ? mem[widx[AW-1:0]] : '0;

    // Reset takes priority over a same-edge write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DM_WORDS; i++) mem[i] <= '0;
        end else if (mem_wr && in_range) begin
            mem[widx[AW-1:0]] <= mem_wdata;
        end
    end
endmodule

// File: tb/tb_mips_exec_mem_unit.sv
// tb_mips_exec_mem_unit: random and directed checks against a behavioural model
module tb_mips_exec_mem_unit;
    localparam int DM = 128;

    logic clk = 1'b0;
    logic rst;
    logic [5:0] opcode, funct;
    logic regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch_eq, branch_ne, jump;
    logic [3:0] aluctl, alu_ctl;
    logic [31:0] alu_a, alu_b, alu_out, mem_addr, mem_wdata, mem_rdata;
    logic alu_zero, mem_rd, mem_wr;
    logic [31:0] ref_mem [DM];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_exec_mem_unit #(.DM_WORDS(DM)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
        .regdst(regdst), .alusrc(alusrc), .memtoreg(memtoreg), .regwrite(regwrite),
        .memread(memread), .memwrite(memwrite), .branch_eq(branch_eq),
        .branch_ne(branch_ne), .jump(jump), .aluctl(aluctl),
        .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
        .alu_zero(alu_zero), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    wire [12:0] dec_vec = {regdst, alusrc, memtoreg, regwrite, memread, memwrite,
                           branch_eq, branch_ne, jump, aluctl};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Decoder table: {regdst,alusrc,memtoreg,regwrite,memread,memwrite,beq,bne,jump,aluctl}
    function automatic logic [12:0] dec_ref(input logic [5:0] op, input logic [5:0] fn);
        int code;
        code = -1;
        if (op == 6'b000000) begin
            if (fn == 6'b100000) code = 2;
            if (fn == 6'b100010) code = 6;
            if (fn == 6'b100100) code = 0;
            if (fn == 6'b100101) code = 1;
            if (fn == 6'b101010) code = 7;
`ifdef ALU_EXT_OPS_EN
            if (fn == 6'b100111) code = 12;
            if (fn == 6'b100110) code = 13;
`endif
            return code < 0 ? 13'b1_0000_0000_0000 : {4'b1001, 5'b0, code[3:0]};
        end
        if (op == 6'b100011) return 13'b0111_1000_0_0010;
        if (op == 6'b101011) return 13'b0100_0100_0_0010;
        if (op == 6'b000100) return 13'b0000_0010_0_0110;
        if (op == 6'b000101) return 13'b0000_0001_0_0110;
        if (op == 6'b001000) return 13'b0101_0000_0_0010;
        if (op == 6'b001100) return 13'b0101_0000_0_0000;
        if (op == 6'b001101) return 13'b0101_0000_0_0001;
        if (op == 6'b001010) return 13'b0101_0000_0_0111;
        if (op == 6'b000010) return 13'b0000_0000_1_0010;
        return 13'b0;
    endfunction

    function automatic logic [31:0] alu_ref(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        if (c == 0) return a & b;
        if (c == 1) return a | b;
        if (c == 2) return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
        if (c == 6) return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
        if (c == 7) return sa < sb ? 32'd1 : 32'd0;
`ifdef ALU_EXT_OPS_EN
        if (c == 12) return ~(a | b);
        if (c == 13) return a ^ b;
`endif
        return 32'd0;
    endfunction

    // Checks all combinational outputs, then advances one clock and updates the model.
    task automatic tick();
        logic [31:0] exp_alu, exp_rd;
        int idx;
        #1;
        exp_alu = alu_ref(alu_ctl, alu_a, alu_b);
        idx = int'(mem_addr >> 2);
        exp_rd = (mem_rd && mem_addr < DM * 4) ? ref_mem[idx] : 32'd0;
        check("decode", 32'(dec_vec), 32'(dec_ref(opcode, funct)));
        check("alu_out", alu_out, exp_alu);
        check("alu_zero", 32'(alu_zero), 32'(exp_alu == 0));
        check("mem_rdata", mem_rdata, exp_rd);
        @(posedge clk);
        if (rst) foreach (ref_mem[i]) ref_mem[i] = 0;
        else if (mem_wr && mem_addr < DM * 4) ref_mem[idx] = mem_wdata;
        #1;
    endtask

    task automatic mem_op(input logic [31:0] a, input logic rd, input logic wr, input logic [31:0] d);
        mem_addr = a;
        mem_rd = rd;
        mem_wr = wr;
        mem_wdata = d;
    endtask

    logic [5:0] ops [11] = '{6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h02, 6'h3f};
    logic [5:0] fns [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2a, 6'h27, 6'h26, 6'h3f};
    logic [31:0] edges [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    initial begin
        foreach (ref_mem[i]) ref_mem[i] = 32'hA5A5_A5A5;
        rst = 1'b1;
        opcode = 6'h00; funct = 6'h20; alu_ctl = 4'd2; alu_a = 0; alu_b = 0;
        mem_op(0, 1'b0, 1'b0, 0);
        @(posedge clk); #1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < DM; i += 37) begin
            mem_op(32'(i * 4), 1'b1, 1'b0, 0);
            #1;
            check("reset_read", mem_rdata, 32'd0);
        end

        opcode = 6'b100011;
        #1 check("dec_lw", 32'(dec_vec), 32'(13'b0111_1000_0_0010));
        opcode = 6'b111111;
        #1 check("dec_nop", 32'(dec_vec), 32'd0);
        opcode = 6'b000000; funct = 6'b100010;
        #1 check("dec_sub", 32'(dec_vec), 32'(13'b1001_0000_0_0110));
        funct = 6'b111111;
        #1 check("dec_badfn", 32'(dec_vec), 32'(13'b1000_0000_0_0000));
        funct = 6'b100111;
`ifdef ALU_EXT_OPS_EN
        #1 check("dec_nor", 32'(dec_vec), 32'(13'b1001_0000_0_1100));
`else
        #1 check("dec_nor_off", 32'(dec_vec), 32'(13'b1000_0000_0_0000));
`endif
        alu_ctl = 4'b0010; alu_a = 32'hFFFFFFFF; alu_b = 32'd1;
        #1 check("add_wrap", alu_out, 32'd0);
        check("add_zero", 32'(alu_zero), 32'd1);
        alu_ctl = 4'b0110; alu_a = 32'd5; alu_b = 32'd7;
        #1 check("sub_neg", alu_out, 32'hFFFFFFFE);
        check("sub_zero", 32'(alu_zero), 32'd0);
        alu_ctl = 4'b0111; alu_a = 32'h80000000; alu_b = 32'd1;
        #1 check("slt_signed", alu_out, 32'd1);
        alu_ctl = 4'b1001; alu_a = 32'h1234; alu_b = 32'h1;
        #1 check("alu_undef", alu_out, 32'd0);
        check("alu_undef_zero", 32'(alu_zero), 32'd1);

        mem_op(32'h10, 1'b1, 1'b1, 32'hDEADBEEF);
        #1 check("rd_before_wr", mem_rdata, 32'd0);
        tick();
        mem_op(32'h13, 1'b1, 1'b0, 0);
        #1 check("rd_after_wr", mem_rdata, 32'hDEADBEEF);
        mem_rd = 1'b0;
        #1 check("rd_disabled", mem_rdata, 32'd0);
        mem_op(32'h0, 1'b0, 1'b1, 32'h1111_2222);
        tick();
        mem_op(DM * 4, 1'b0, 1'b1, 32'hCAFEF00D);
        tick();
        mem_op(DM * 4, 1'b1, 1'b0, 0);
        #1 check("oob_read", mem_rdata, 32'd0);
        mem_op(0, 1'b1, 1'b0, 0);
        #1 check("word0_kept", mem_rdata, 32'h1111_2222);

        for (int n = 0; n < 400; n++) begin
            opcode = $urandom_range(3) == 0 ? 6'($urandom) : ops[$urandom_range(10)];
            funct = $urandom_range(3) == 0 ? 6'($urandom) : fns[$urandom_range(7)];
            alu_ctl = $urandom_range(3) == 0 ? 4'($urandom) : 4'(edges[0] + {$urandom_range(1), 2'b00} | 4'($urandom_range(7)));
            alu_a = $urandom_range(2) == 0 ? edges[$urandom_range(4)] : $urandom;
            alu_b = $urandom_range(2) == 0 ? edges[$urandom_range(4)] : $urandom;
            if (alu_ctl == 4'd6 && $urandom_range(4) == 0) alu_b = alu_a;
            mem_op(32'($urandom_range(DM * 4 + 31)), 1'($urandom), 1'($urandom), $urandom);
            rst = $urandom_range(60) == 0;
            tick();
        end
        rst = 1'b0;

        mem_op(32'h8, 1'b0, 1'b1, 32'h5555_AAAA);
        tick();
        rst = 1'b1;
        mem_op(0, 1'b0, 1'b1, 32'h7777_7777);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            mem_op(32'(i * 4), 1'b1, 1'b0, 0);
            #1 check("rst_clear", mem_rdata, 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
